// File: rtl/adc_project_top_pkg.sv
// Shared defaults, ADC source type and seven-segment encoder for the SAR voltmeter.
`default_nettype none

package adc_project_top_pkg;

  localparam int CLK_HZ_DEF          = 100_000_000;
  localparam int SETTLE_CYCLES_DEF   = 6250;
  localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;
  localparam int DIGIT_CYCLES_DEF    = 100_000;
  localparam int VREF_MV_DEF         = 3300;

  typedef enum logic {
    SRC_R2R = 1'b0,
    SRC_PWM = 1'b1
  } adc_src_t;

  // Returns {CA,CB,CC,CD,CE,CF,CG}, active-low; b and d are lower-case glyphs.
  function automatic logic [6:0] seg7_encode(input logic [3:0] i_nib);
    logic [6:0] w_on;
    case (i_nib)
      4'h0: w_on = 7'b1111110;
      4'h1: w_on = 7'b0110000;
      4'h2: w_on = 7'b1101101;
      4'h3: w_on = 7'b1111001;
      4'h4: w_on = 7'b0110011;
      4'h5: w_on = 7'b1011011;
      4'h6: w_on = 7'b1011111;
      4'h7: w_on = 7'b1110000;
      4'h8: w_on = 7'b1111111;
      4'h9: w_on = 7'b1111011;
      4'hA: w_on = 7'b1110111;
      4'hB: w_on = 7'b0011111;
      4'hC: w_on = 7'b1001110;
      4'hD: w_on = 7'b0111101;
      4'hE: w_on = 7'b1001111;
      default: w_on = 7'b1000111;
    endcase
    return ~w_on;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_engine.sv
// Free-running 8-bit successive-approximation engine: one trial per settle window.
`default_nettype none

module sar_engine
  import adc_project_top_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_restart,
  input  logic       i_comp,
  output logic [7:0] o_trial,
  output logic [7:0] o_result
);

  localparam int              TW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0]   c_last = TW'(SETTLE_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit;
  logic [7:0]    r_code;
  logic [7:0]    r_result;
  logic [7:0]    w_trial;
  logic [7:0]    w_kept;

  assign w_trial = r_code | (8'b1 << r_bit);
  // r_code never holds the bit under trial, so a 0 decision simply keeps r_code.
  assign w_kept  = i_comp ? w_trial : r_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= '0;
      r_bit    <= 3'd7;
      r_code   <= 8'h00;
      r_result <= 8'h00;
    end else if (i_restart) begin
      r_timer <= '0;
      r_bit   <= 3'd7;
      r_code  <= 8'h00;
    end else if (r_timer == c_last) begin
      r_timer <= '0;
      if (r_bit == 3'd0) begin
        r_result <= w_kept;
        r_code   <= 8'h00;
        r_bit    <= 3'd7;
      end else begin
        r_code <= w_kept;
        r_bit  <= r_bit - 3'd1;
      end
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_trial  = w_trial;
  assign o_result = r_result;

endmodule

`default_nettype wire

// File: rtl/adc_project_top.sv
// Dual-DAC SAR voltmeter top: button debounce, DAC routing, BCD conversion and display mux.
`default_nettype none

module adc_project_top
  import adc_project_top_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DIGIT_CYCLES    = DIGIT_CYCLES_DEF,
  parameter int VREF_MV         = VREF_MV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] switches_in,
  input  logic        comp_r2r,
  input  logic        comp_pwm,
  input  logic        adc_mode_bt,
  input  logic        scaled_mode_bt,
  input  logic        display_mode_bt,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        AN4,
  output logic [15:0] led,
  output logic        pwm_out,
  output logic [7:0]  R2R_out
);

  localparam int              DBW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0]  c_db_last  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int              DGW        = $clog2(DIGIT_CYCLES + 1);
  localparam logic [DGW-1:0]  c_dig_last = DGW'(DIGIT_CYCLES - 1);

  // Button/mode index: 0 = adc source, 1 = scaled, 2 = decimal display.
  logic [2:0]          r_btn_meta, r_btn_sync, r_btn_db, r_mode;
  logic [2:0][DBW-1:0] r_db_cnt;
  logic [1:0]          r_comp_meta, r_comp_sync;
  logic [2:0]          w_db_hit, w_toggle;
  adc_src_t            w_src;
  logic                w_comp;
  logic [7:0]          w_trial, w_result;
  logic [7:0]          r_pwm_cnt, r_r2r;
  logic                r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_meta  <= 3'b000;
      r_btn_sync  <= 3'b000;
      r_comp_meta <= 2'b00;
      r_comp_sync <= 2'b00;
    end else begin
      r_btn_meta  <= {display_mode_bt, scaled_mode_bt, adc_mode_bt};
      r_btn_sync  <= r_btn_meta;
      r_comp_meta <= {comp_pwm, comp_r2r};
      r_comp_sync <= r_comp_meta;
    end
  end

  always_comb begin
    w_db_hit = 3'b000;
    w_toggle = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_db_hit[i] = (r_btn_sync[i] != r_btn_db[i]) && (r_db_cnt[i] == c_db_last);
      w_toggle[i] = w_db_hit[i] && r_btn_sync[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_db <= 3'b000;
      r_db_cnt <= '0;
      r_mode   <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_btn_sync[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_hit[i]) begin
          r_btn_db[i] <= r_btn_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
      r_mode <= r_mode ^ w_toggle;
    end
  end

  assign w_src  = adc_src_t'(r_mode[0]);
  assign w_comp = (w_src == SRC_PWM) ? r_comp_sync[1] : r_comp_sync[0];

  // Switching DAC source invalidates the trial in flight, so restart on the same edge.
  sar_engine #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_sar (
    .clk      (clk),
    .reset    (reset),
    .i_restart(w_toggle[0]),
    .i_comp   (w_comp),
    .o_trial  (w_trial),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= 8'h00;
      r_pwm     <= 1'b0;
      r_r2r     <= 8'h00;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm     <= (w_src == SRC_PWM) && (r_pwm_cnt < w_trial);
      r_r2r     <= (w_src == SRC_R2R) ? w_trial : 8'h00;
    end
  end

  logic [7:0]  r_disp_code;
  logic [15:0] r_led;
  logic [19:0] w_prod;
  logic [11:0] w_bcd_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_code <= 8'h00;
      r_led       <= 16'h0000;
    end else begin
      if (!switches_in[0]) r_disp_code <= w_result;
      r_led <= {r_mode[0], r_mode[1], r_mode[2], 5'b00000, r_disp_code};
    end
  end

  assign w_prod    = 20'(r_disp_code) * 20'(VREF_MV);
  assign w_bcd_src = r_mode[1] ? w_prod[19:8] : {4'h0, r_disp_code};

  // Continuous double-dabble: reload, 12 shift steps, publish; repeats every 13 cycles.
  logic [3:0]  r_dd_cnt;
  logic [11:0] r_dd_bin;
  logic [15:0] r_dd_bcd, r_bcd, w_bcd_adj, w_bcd_shift;

  always_comb begin
    w_bcd_adj = r_dd_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_dd_bcd[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = r_dd_bcd[4*n +: 4] + 4'd3;
    end
  end
  assign w_bcd_shift = {w_bcd_adj[14:0], r_dd_bin[11]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dd_cnt <= 4'd0;
      r_dd_bin <= 12'h000;
      r_dd_bcd <= 16'h0000;
      r_bcd    <= 16'h0000;
    end else if (r_dd_cnt == 4'd0) begin
      r_dd_bin <= w_bcd_src;
      r_dd_bcd <= 16'h0000;
      r_dd_cnt <= 4'd12;
    end else begin
      r_dd_bcd <= w_bcd_shift;
      r_dd_bin <= {r_dd_bin[10:0], 1'b0};
      r_dd_cnt <= r_dd_cnt - 4'd1;
      if (r_dd_cnt == 4'd1) r_bcd <= w_bcd_shift;
    end
  end

  logic [DGW-1:0] r_dig_timer;
  logic [1:0]     r_dig_sel;
  logic [15:0]    w_digits;
  logic [3:0]     w_nib;
  logic [3:0]     r_an;
  logic [6:0]     r_seg;
  logic           r_dp;

  assign w_digits = (!r_mode[1] && !r_mode[2]) ? {8'h00, r_disp_code} : r_bcd;

  always_comb begin
    w_nib = w_digits[3:0];
    case (r_dig_sel)
      2'd0:    w_nib = w_digits[15:12];
      2'd1:    w_nib = w_digits[11:8];
      2'd2:    w_nib = w_digits[7:4];
      default: w_nib = w_digits[3:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dig_timer <= '0;
      r_dig_sel   <= 2'd0;
      r_an        <= 4'b1111;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
    end else begin
      if (r_dig_timer == c_dig_last) begin
        r_dig_timer <= '0;
        r_dig_sel   <= r_dig_sel + 2'd1;
      end else begin
        r_dig_timer <= r_dig_timer + 1'b1;
      end
      r_an  <= ~(4'b1000 >> r_dig_sel);
      r_seg <= seg7_encode(w_nib);
      r_dp  <= ~(r_mode[1] && (r_dig_sel == 2'd0));
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
  assign DP                           = r_dp;
  assign {AN1, AN2, AN3, AN4}         = r_an;
  assign led                          = r_led;
  assign pwm_out                      = r_pwm;
  assign R2R_out                      = r_r2r;

  logic w_unused_ok;
  assign w_unused_ok = ^{switches_in[15:1], w_prod[7:0], w_bcd_adj[15], 1'(CLK_HZ & 1)};

endmodule

`default_nettype wire

// File: tb/tb_adc_project_top.sv
// Directed, table-driven bench for adc_project_top with shortened timing parameters.
`default_nettype none

module tb_adc_project_top;

  localparam int SETTLE = 8;
  localparam int DEB    = 16;
  localparam int DIG    = 4;
  localparam int CONV   = 8 * SETTLE;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] switches_in;
  logic        comp_r2r, comp_pwm;
  logic [2:0]  btn;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, AN1, AN2, AN3, AN4;
  logic [15:0] led;
  logic        pwm_out;
  logic [7:0]  R2R_out;
  int          vin_x2;

  int n_pass  = 0;
  int n_total = 0;
  bit cur_adc, cur_scaled, cur_disp;

  always #5 clk = ~clk;

  // Ideal comparator on the ladder; Vin is held half an LSB above an integer code.
  assign comp_r2r = (vin_x2 > 2 * int'(R2R_out));

  adc_project_top #(
    .CLK_HZ(100_000_000), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB),
    .DIGIT_CYCLES(DIG), .VREF_MV(3300)
  ) dut (
    .clk(clk), .reset(reset), .switches_in(switches_in),
    .comp_r2r(comp_r2r), .comp_pwm(comp_pwm),
    .adc_mode_bt(btn[0]), .scaled_mode_bt(btn[1]), .display_mode_bt(btn[2]),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP),
    .AN1(AN1), .AN2(AN2), .AN3(AN3), .AN4(AN4),
    .led(led), .pwm_out(pwm_out), .R2R_out(R2R_out)
  );

  typedef struct {
    int         vin;
    bit         scaled;
    bit         disp;
    logic [7:0] code;
    logic [15:0] digits;
    bit         dp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] tb_seg(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'h0: on = 7'b1111110; 4'h1: on = 7'b0110000; 4'h2: on = 7'b1101101;
      4'h3: on = 7'b1111001; 4'h4: on = 7'b0110011; 4'h5: on = 7'b1011011;
      4'h6: on = 7'b1011111; 4'h7: on = 7'b1110000; 4'h8: on = 7'b1111111;
      4'h9: on = 7'b1111011; 4'hA: on = 7'b1110111; 4'hB: on = 7'b0011111;
      4'hC: on = 7'b1001110; 4'hD: on = 7'b0111101; 4'hE: on = 7'b1001111;
      default: on = 7'b1000111;
    endcase
    return ~on;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input int len);
    @(negedge clk);
    btn[idx] = 1'b1;
    wait_cycles(len);
    btn[idx] = 1'b0;
    wait_cycles(DEB + 8);
  endtask

  task automatic set_modes(input bit s, input bit d);
    if (cur_scaled != s) begin press(1, DEB + 8); cur_scaled = s; end
    if (cur_disp != d) begin press(2, DEB + 8); cur_disp = d; end
  endtask

  task automatic read_display(output logic [27:0] segs, output logic [3:0] dps, output logic ok);
    logic [3:0] seen;
    logic [3:0] an;
    logic       bad;
    int         idx;
    seen = 4'h0; bad = 1'b0; segs = '1; dps = '1;
    for (int c = 0; c < 100 && seen != 4'hF; c++) begin
      @(negedge clk);
      an  = {AN1, AN2, AN3, AN4};
      idx = -1;
      case (an)
        4'b0111: idx = 0;
        4'b1011: idx = 1;
        4'b1101: idx = 2;
        4'b1110: idx = 3;
        default: bad = 1'b1;
      endcase
      if (idx >= 0) begin
        segs[27-7*idx -: 7] = {CA, CB, CC, CD, CE, CF, CG};
        dps[3-idx]          = DP;
        seen[idx]           = 1'b1;
      end
    end
    ok = (seen == 4'hF) && !bad;
  endtask

  task automatic check_display(input string name, input logic [15:0] digits, input bit dp);
    logic [27:0] segs;
    logic [3:0]  dps;
    logic        ok;
    read_display(segs, dps, ok);
    chk({name, "_scan"}, ok, 1);
    chk({name, "_segs"}, segs,
        {tb_seg(digits[15:12]), tb_seg(digits[11:8]), tb_seg(digits[7:4]), tb_seg(digits[3:0])});
    chk({name, "_dp"}, dps, dp ? 4'b0111 : 4'b1111);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[3];
    logic [7:0] last;
    int         nseq, hi_cnt, r2r_cnt;

    vecs[0] = '{511, 0, 0, 8'hFF, 16'h00FF, 0};
    vecs[1] = '{437, 0, 0, 8'hDA, 16'h00DA, 0};
    vecs[2] = '{437, 0, 1, 8'hDA, 16'h0218, 0};
    vecs[3] = '{437, 1, 0, 8'hDA, 16'h2810, 1};
    vecs[4] = '{437, 1, 1, 8'hDA, 16'h2810, 1};
    vecs[5] = '{0,   1, 1, 8'h00, 16'h0000, 1};
    vecs[6] = '{511, 0, 1, 8'hFF, 16'h0255, 0};
    vecs[7] = '{201, 0, 0, 8'h64, 16'h0064, 0};
    vecs[8] = '{201, 0, 1, 8'h64, 16'h0100, 0};
    vecs[9] = '{21,  1, 0, 8'h0A, 16'h0128, 1};

    reset = 1'b1; switches_in = 16'h0000; comp_pwm = 1'b0; btn = 3'b000; vin_x2 = 511;
    cur_adc = 0; cur_scaled = 0; cur_disp = 0;
    #30;
    chk("rst_r2r", R2R_out, 8'h00);
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_led", led, 16'h0000);
    chk("rst_an", {AN1, AN2, AN3, AN4}, 4'hF);
    chk("rst_seg", {CA, CB, CC, CD, CE, CF, CG}, 7'h7F);
    chk("rst_dp", DP, 1'b1);

    // Trial codes seen on the ladder with the comparator always saying "higher".
    @(negedge clk);
    reset = 1'b0;
    nseq = 0; last = 8'h00;
    for (int c = 0; c < 100 && nseq < 3; c++) begin
      @(negedge clk);
      if (R2R_out != last) begin seq[nseq] = R2R_out; nseq++; last = R2R_out; end
    end
    chk("seq_count", nseq, 3);
    chk("seq0", seq[0], 8'h80);
    chk("seq1", seq[1], 8'hC0);
    chk("seq2", seq[2], 8'hE0);
    chk("one_an", $countones(~{AN1, AN2, AN3, AN4}), 1);

    for (int v = 0; v < 10; v++) begin
      set_modes(vecs[v].scaled, vecs[v].disp);
      vin_x2 = vecs[v].vin;
      wait_cycles(3 * CONV);
      chk($sformatf("v%0d_code", v), led[7:0], vecs[v].code);
      chk($sformatf("v%0d_modes", v), led[15:8], {1'b0, vecs[v].scaled, vecs[v].disp, 5'b0});
      check_display($sformatf("v%0d", v), vecs[v].digits, vecs[v].dp);
    end

    // Display hold freezes the shown code while conversions continue.
    set_modes(0, 0);
    vin_x2 = 437;
    wait_cycles(3 * CONV);
    switches_in[0] = 1'b1;
    vin_x2 = 201;
    wait_cycles(3 * CONV);
    chk("hold_led", led[7:0], 8'hDA);
    check_display("hold", 16'h00DA, 0);
    switches_in[0] = 1'b0;
    wait_cycles(2 * CONV);
    chk("unhold_led", led[7:0], 8'h64);

    // A pulse shorter than the debounce window must not toggle anything.
    press(1, DEB / 2);
    wait_cycles(2 * DEB);
    chk("glitch_modes", led[15:13], 3'b000);

    // PWM source.
    press(0, DEB + 8); cur_adc = 1;
    comp_pwm = 1'b0;
    wait_cycles(3 * CONV);
    chk("pwm_mode", led[15], 1'b1);
    chk("pwm_res0", led[7:0], 8'h00);
    hi_cnt = 0; r2r_cnt = 0;
    for (int c = 0; c < 4 * CONV; c++) begin
      @(negedge clk);
      if (pwm_out) hi_cnt++;
      if (R2R_out != 8'h00) r2r_cnt++;
    end
    chk("pwm_active", hi_cnt > 0, 1);
    chk("pwm_r2r_zero", r2r_cnt, 0);
    comp_pwm = 1'b1;
    wait_cycles(3 * CONV);
    chk("pwm_resFF", led[7:0], 8'hFF);
    for (int p = 0; p < 3; p++) press(0, DEB + 8);
    cur_adc = 0;
    chk("four_press", led[15], 1'b0);
    vin_x2 = 437;
    wait_cycles(3 * CONV);
    hi_cnt = 0;
    for (int c = 0; c < CONV; c++) begin
      @(negedge clk);
      if (pwm_out) hi_cnt++;
    end
    chk("r2r_pwm_idle", hi_cnt, 0);
    chk("r2r_back_code", led[7:0], 8'hDA);

    // Asynchronous reset in the middle of a conversion.
    press(1, DEB + 8);
    wait_cycles(CONV / 2 + 3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_r2r", R2R_out, 8'h00);
    chk("mid_rst_led", led, 16'h0000);
    chk("mid_rst_an", {AN1, AN2, AN3, AN4}, 4'hF);
    chk("mid_rst_seg", {CA, CB, CC, CD, CE, CF, CG, DP}, 8'hFF);
    chk("mid_rst_pwm", pwm_out, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cur_scaled = 0;
    wait_cycles(3 * CONV);
    chk("post_rst_code", led, 16'h00DA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_project_top.md
Name: adc_project_top

Overview:
FPGA top level of a dual-method 8-bit successive-approximation (SAR) voltmeter running on a 100 MHz board clock.
- One SAR engine drives either an external R2R ladder (R2R_out) or a PWM DAC (pwm_out, external RC filter). It reads the matching external comparator.
- The result goes to LEDs and to a 4-digit multiplexed seven-segment display as raw hex, raw decimal, or scaled millivolts.
- Three debounced push-buttons select the mode.

Parameters:
CLK_HZ, 100_000_000, system clock frequency.
SETTLE_CYCLES, 6250, cycles per SAR bit trial (62.5 us); 8 trials = 500 us per conversion.
DEBOUNCE_CYCLES, 2_000_000, cycles a button must be stable (20 ms).
DIGIT_CYCLES, 100_000, display refresh time per digit (1 ms).
VREF_MV, 3300, full-scale voltage in mV for scaled mode.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
switches_in  in  16  bit0 = display hold; bits 15:1 ignored
comp_r2r  in  1  R2R comparator, 1 = Vin > DAC voltage
comp_pwm  in  1  PWM-DAC comparator, 1 = Vin > DAC voltage
adc_mode_bt  in  1  toggles ADC source
scaled_mode_bt  in  1  toggles raw/scaled display
display_mode_bt  in  1  toggles hex/decimal for raw display
CA,CB,CC,CD,CE,CF,CG  out  1 each  segments, active-low
DP  out  1  decimal point, active-low
AN1..AN4  out  1 each  digit enables, active-low; AN1 = most-significant digit
led  out  16  status and result
pwm_out  out  1  PWM DAC output
R2R_out  out  8  R2R ladder code

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: all mode bits 0, result 0x00, R2R_out = 0, pwm_out = 0, led = 0. All segments, DP and AN1..AN4 are high (blank). The SAR engine restarts at bit 7.
- Input synchronisation: comp_r2r, comp_pwm and the three buttons each pass through a 2-FF synchroniser.
- Buttons: a debounced level changes only after the input has been stable for DEBOUNCE_CYCLES. A rising edge of the debounced level toggles that button's mode bit. Holding a button produces exactly one toggle.
- Mode bits:
  - adc_mode: 0 = R2R, 1 = PWM.
  - scaled_mode: 0 = raw, 1 = millivolts.
  - display_mode: 0 = hex, 1 = decimal. Applies to raw display only.
- SAR conversion loop (free-running, repeats forever):
  - For bit k = 7 down to 0: trial = kept bits OR (1 << k). Hold trial on the active DAC for SETTLE_CYCLES.
  - On the last cycle of that window, sample the selected synchronised comparator. If 1, keep bit k; if 0, clear it.
  - After bit 0, load the 8-bit result register and restart at bit 7 with a zero code.
  - Result latency is 8*SETTLE_CYCLES cycles from the start of a conversion.
- DAC routing:
  - adc_mode = 0: R2R_out = trial; pwm_out held at 0.
  - adc_mode = 1: pwm_out is high while a free-running 8-bit counter (period 256 cycles) is less than trial; R2R_out = 0.
  - A mode change mid-conversion aborts it and restarts at bit 7. The result register keeps its old value.
- Display hold: while switches_in[0] = 1, the displayed and LED value freezes; conversions continue.
- Display value:
  - Raw hex: "00" followed by two hex digits, e.g. 0xDA shows "00dA".
  - Raw decimal: 4 BCD digits with leading zeros, e.g. "0218".
  - Scaled: mV = (code*VREF_MV) >> 8, truncated, shown as 4 decimal digits. DP is lit on the AN1 digit (V.mmm), e.g. 0xDA shows "2.810".
  - DP is off in every other case.
- Multiplexing: each digit is active for DIGIT_CYCLES, order AN1, AN2, AN3, AN4, then repeat. Exactly one AN is low at a time after reset.
- LEDs: led[7:0] = displayed code, led[15] = adc_mode, led[14] = scaled_mode, led[13] = display_mode, led[12:8] = 0.
- Binary-to-BCD conversion: may be sequential (double-dabble). It must complete within one conversion period.

Decomposition:
- Shared package holds:
  - the parameter defaults;
  - a seven-segment encoding function for 0-F, active-low CA..CG ordering;
  - the mode typedefs (adc_src_t {SRC_R2R, SRC_PWM}).
- One natural sub-module: sar_engine. It contains the bit counter, settle timer, trial register and result register; its inputs are the comparator bit and a restart signal.
- Debouncing, PWM generation, BCD conversion and display mux stay in the top level.

Test Plan:
- Reset 30 ns then release -> R2R_out = 0, pwm_out = 0, led = 0, one AN low, "0000"-pattern cleared state.
- comp_r2r held 1, R2R mode -> after 500 us result = 0xFF, led[7:0] = 0xFF, display "00FF". R2R_out sequence 0x80, 0xC0, 0xE0, ...
- comp_r2r bit pattern 1,1,0,1,1,0,1,0, each bit aligned to a 62.5 us window -> result 0xDA. With scaled_mode toggled on: display "2.810", DP lit on AN1.
- Press display_mode_bt for 51 ms, scaled off, result 0xDA -> display "0218", led[13] = 1. Press again -> "00dA".
- Press adc_mode_bt for 51 ms -> led[15] = 1, R2R_out = 0, pwm_out duty tracks the trial code. With comp_pwm = 0, result = 0x00. Four presses return to R2R mode.
- Button glitch shorter than DEBOUNCE_CYCLES -> no mode toggle. Assert reset mid-conversion -> all outputs return to reset values immediately.
